sti_rx: RTL and testbench
=========================

Name: sti_rx

Overview:
- Serial-to-parallel receiver: the inverse of the STI serializer. It reconstructs the 16-bit parallel word from the so_data/so_valid serial stream.
- Uses the same frame format controls as the transmitter: length, fill, msb-first and low-byte select.
- Sits at the far end of the serial link; used as a loopback checker and as the receive path in the link partner.
- Reports each recovered word with a one-cycle valid pulse and a frame error flag.

Parameters:
- FCNT_W, 8, width of the received-frame counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- cfg_load  input  1  latch cfg_* on this cycle; accepted only in IDLE
- cfg_length  input  2  00=8b, 01=16b, 10=24b, 11=32b frame
- cfg_fill  input  1  for 24/32b frames: 1 = data in upper bits, zero pad below; 0 = data in lower bits, zero pad above
- cfg_msb  input  1  1 = first serial bit is frame MSB; 0 = first bit is frame LSB
- cfg_low  input  1  for 8b frames: 1 = byte maps to po_data[7:0]; 0 = maps to po_data[15:8]
- si_data  input  1  serial data bit
- si_valid  input  1  high for each valid bit; one contiguous run = one frame
- po_data  output  16  recovered word
- po_valid  output  1  one-cycle pulse, po_data and po_err valid
- po_err  output  1  frame error, qualified by po_valid
- frame_cnt  output  FCNT_W  count of po_valid pulses, wraps modulo 2^FCNT_W
- rx_busy  output  1  high while a frame is being received

Behaviour:
- Reset values: po_data=0, po_valid=0, po_err=0, frame_cnt=0, rx_busy=0, state=IDLE, cfg regs=0 (8b, lsb-first, high byte), shift reg=0, bit count=0.
- Frame length L: 8/16/24/32 from latched cfg_length.
- Frame word W (transmitter definition):
  - L=8: W = cfg_low ? d[7:0] : d[15:8].
  - L=16: W = d.
  - L=24: W = fill ? {d,8'h00} : {8'h00,d}.
  - L=32: W = fill ? {d,16'h0000} : {16'h0000,d}.
- States:
  - IDLE: cfg_load latches cfg_*. si_valid=1 loads the first bit, sets count=1, goes to RECV, rx_busy=1.
  - RECV: each cycle with si_valid=1 shifts in one bit and increments count. count saturates at 33 (overflow marker; excess bits not stored). On the first cycle sampling si_valid=0, go to DONE.
  - DONE: registers the outputs, pulses po_valid for exactly one cycle, frame_cnt+1, returns to IDLE.
- Shift rules:
  - msb-first: sr <= {sr[30:0], si_data}; W = sr[L-1:0].
  - lsb-first: sr <= {si_data, sr[31:1]}; W = sr[31:32-L].
- Extraction to po_data:
  - L=8: cfg_low ? {8'h00,W[7:0]} : {W[7:0],8'h00}.
  - L=16: W[15:0].
  - L=24: fill ? W[23:8] : W[15:0].
  - L=32: fill ? W[31:16] : W[15:0].
- Latency: po_valid is high in the cycle after the edge that first samples si_valid=0 following the last bit, i.e. 2 cycles after the last bit's sampling edge.
- po_err=1 when count != L. In that case po_data=0, po_valid still pulses and frame_cnt still increments.
- A new frame may start (si_valid=1) in the DONE cycle. Its first bit is captured and the block goes directly to RECV with no bit lost.
- cfg_load outside IDLE is ignored. cfg_load and si_valid in the same IDLE cycle: the new config applies to this frame.
- reset mid-frame: everything returns to reset values. The partial frame is discarded with no po_valid.

Optional Feature:
- Macro: STI_RX_FILL_CHECK_EN.
- Defined: for L=24/32, the padding bits of W must be zero. For L=8 and L=16 there is no check. Any nonzero padding bit sets po_err=1 and forces po_data=0.
- Not defined: padding bits are ignored and po_err reflects only the length mismatch.

Test Plan:
- cfg 8b, msb, low=1; serial 1,0,1,0,0,1,0,1 -> po_valid one cycle, po_data=16'h00A5, po_err=0, frame_cnt=1.
- cfg 16b, lsb-first; bits of 16'h12A5 sent LSB first -> po_data=16'h12A5, po_err=0.
- cfg 32b, fill=1, msb; send {16'hBEEF,16'h0000} -> po_data=16'hBEEF. Repeat with padding 16'h0001: po_err=1, po_data=0 when STI_RX_FILL_CHECK_EN is defined; po_data=16'hBEEF, po_err=0 when it is not.
- cfg 24b; only 20 bits sent -> po_valid with po_err=1, po_data=0. Then 40 bits sent -> po_err=1.
- Back-to-back frames: 16b 16'h1234, then 16'h5678 starting in the DONE cycle -> two pulses with the correct data, frame_cnt=2.
- Assert reset after 5 bits of a 16b frame -> no po_valid. The next full frame decodes correctly.

Source files
------------

// File: rtl/sti_rx.sv
// rtl/sti_rx.sv - STI serial-to-parallel receiver
// Optional padding check enabled by defining STI_RX_FILL_CHECK_EN.
module sti_rx #(
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_fill,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  input  logic              si_data,
  input  logic              si_valid,
  output logic [15:0]       po_data,
  output logic              po_valid,
  output logic              po_err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              rx_busy
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  len_q;
  logic        fill_q, msb_q, low_q;
  logic [31:0] sr;
  logic [5:0]  cnt;

  logic        take_cfg;
  logic        msb_eff;
  logic [5:0]  frame_len;
  logic [31:0] w;
  logic [15:0] data_x;
  logic        pad_nz;
  logic        err;

  assign take_cfg = (state == IDLE) && cfg_load;
  assign msb_eff  = take_cfg ? cfg_msb : msb_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (si_valid) state_next = RECV;
      RECV:    if (!si_valid) state_next = DONE;
      DONE:    state_next = si_valid ? RECV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame word W, right-aligned, from either shift direction.
  always_comb begin
    w         = 32'h0;
    frame_len = 6'd8;
    case (len_q)
      2'b00: begin
        frame_len = 6'd8;
        w = msb_q ? {24'h0, sr[7:0]} : {24'h0, sr[31:24]};
      end
      2'b01: begin
        frame_len = 6'd16;
        w = msb_q ? {16'h0, sr[15:0]} : {16'h0, sr[31:16]};
      end
      2'b10: begin
        frame_len = 6'd24;
        w = msb_q ? {8'h0, sr[23:0]} : {8'h0, sr[31:8]};
      end
      default: begin
        frame_len = 6'd32;
        w = sr;
      end
    endcase
  end

  always_comb begin
    data_x = 16'h0;
    pad_nz = 1'b0;
    case (len_q)
      2'b00: data_x = low_q ? {8'h00, w[7:0]} : {w[7:0], 8'h00};
      2'b01: data_x = w[15:0];
      2'b10: begin
        data_x = fill_q ? w[23:8] : w[15:0];
        pad_nz = fill_q ? (w[7:0] != 8'h0) : (w[23:16] != 8'h0);
      end
      default: begin
        data_x = fill_q ? w[31:16] : w[15:0];
        pad_nz = fill_q ? (w[15:0] != 16'h0) : (w[31:16] != 16'h0);
      end
    endcase
  end

`ifdef STI_RX_FILL_CHECK_EN
  assign err = (cnt != frame_len) || pad_nz;
`else
  assign err = (cnt != frame_len);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= 2'b00;
      fill_q    <= 1'b0;
      msb_q     <= 1'b0;
      low_q     <= 1'b0;
      sr        <= 32'h0;
      cnt       <= 6'd0;
      po_data   <= 16'h0;
      po_valid  <= 1'b0;
      po_err    <= 1'b0;
      frame_cnt <= '0;
      rx_busy   <= 1'b0;
    end else begin
      state    <= state_next;
      rx_busy  <= (state_next != IDLE);
      po_valid <= 1'b0;
      if (take_cfg) begin
        len_q  <= cfg_length;
        fill_q <= cfg_fill;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
      end
      case (state)
        RECV: begin
          // Count runs to 33 as an overflow marker; bits past 32 are dropped.
          if (si_valid && cnt < 6'd33) begin
            cnt <= cnt + 6'd1;
            if (cnt < 6'd32)
              sr <= msb_q ? {sr[30:0], si_data} : {si_data, sr[31:1]};
          end
        end
        default: begin
          if (si_valid) begin
            sr  <= msb_eff ? {31'h0, si_data} : {si_data, 31'h0};
            cnt <= 6'd1;
          end
        end
      endcase
      if (state == DONE) begin
        po_valid  <= 1'b1;
        po_err    <= err;
        po_data   <= err ? 16'h0 : data_x;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sti_rx.sv
// tb/tb_sti_rx.sv - directed self-checking bench for sti_rx
module tb_sti_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [1:0] cfg_length;
  logic       cfg_fill, cfg_msb, cfg_low;
  logic       si_data, si_valid;
  logic [15:0] po_data;
  logic       po_valid, po_err, rx_busy;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit fill_chk;

  sti_rx #(.FCNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_length(cfg_length),
    .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .si_data(si_data), .si_valid(si_valid), .po_data(po_data),
    .po_valid(po_valid), .po_err(po_err), .frame_cnt(frame_cnt),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low;
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [39:0] v, input int n, input bit msb);
    for (int i = 0; i < n; i++) begin
      si_valid = 1'b1;
      si_data  = msb ? v[n-1-i] : v[i];
      step();
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  // Waits (bounded) for the pulse, expecting it two edges after the last bit.
  task automatic expect_frame(input string tag, input logic [15:0] d, input logic e, input logic [7:0] fc);
    int lat = 0;
    while (po_valid !== 1'b1 && lat < 6) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_data"}, {16'h0, po_data}, {16'h0, d});
    chk({tag, "_err"}, {31'h0, po_err}, {31'h0, e});
    chk({tag, "_fcnt"}, {24'h0, frame_cnt}, {24'h0, fc});
    step();
    chk({tag, "_pulse1"}, {31'h0, po_valid}, 32'h0);
  endtask

  initial begin
`ifdef STI_RX_FILL_CHECK_EN
    fill_chk = 1'b1;
`else
    fill_chk = 1'b0;
`endif
    reset = 1'b1; cfg_load = 1'b0; cfg_length = 2'b00; cfg_fill = 1'b0;
    cfg_msb = 1'b0; cfg_low = 1'b0; si_data = 1'b0; si_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_data", {16'h0, po_data}, 32'h0);
    chk("rst_valid", {31'h0, po_valid}, 32'h0);
    chk("rst_err", {31'h0, po_err}, 32'h0);
    chk("rst_fcnt", {24'h0, frame_cnt}, 32'h0);
    chk("rst_busy", {31'h0, rx_busy}, 32'h0);

    // 8b, msb-first, low byte
    load_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    send(40'hA5, 8, 1'b1);
    chk("t8_busy", {31'h0, rx_busy}, 32'h1);
    expect_frame("t8", 16'h00A5, 1'b0, 8'd1);
    chk("t8_idle", {31'h0, rx_busy}, 32'h0);

    // 8b, msb-first, high byte
    load_cfg(2'b00, 1'b0, 1'b1, 1'b0);
    send(40'h3C, 8, 1'b1);
    expect_frame("t8h", 16'h3C00, 1'b0, 8'd2);

    // 16b lsb-first
    load_cfg(2'b01, 1'b0, 1'b0, 1'b0);
    send(40'h12A5, 16, 1'b0);
    expect_frame("t16l", 16'h12A5, 1'b0, 8'd3);

    // 32b fill msb-first, clean and dirty padding
    load_cfg(2'b11, 1'b1, 1'b1, 1'b0);
    send(40'hBEEF0000, 32, 1'b1);
    expect_frame("t32", 16'hBEEF, 1'b0, 8'd4);
    send(40'hBEEF0001, 32, 1'b1);
    if (fill_chk) expect_frame("t32pad", 16'h0000, 1'b1, 8'd5);
    else          expect_frame("t32pad", 16'hBEEF, 1'b0, 8'd5);

    // 24b no-fill lsb-first good frame
    load_cfg(2'b10, 1'b0, 1'b0, 1'b0);
    send(40'h00C3D4, 24, 1'b0);
    expect_frame("t24", 16'hC3D4, 1'b0, 8'd6);

    // 24b short (20 bits) and long (40 bits)
    send(40'hFFFFF, 20, 1'b0);
    expect_frame("t24s", 16'h0000, 1'b1, 8'd7);
    send(40'hFF_FFFF_FFFF, 40, 1'b0);
    expect_frame("t24l", 16'h0000, 1'b1, 8'd8);

    // back-to-back 16b msb-first; second frame starts in DONE cycle
    load_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send(40'h1234, 16, 1'b1);
    step();
    si_valid = 1'b1; si_data = 1'b0;  // bit 15 of 16'h5678
    cfg_load = 1'b1; cfg_length = 2'b00;  // ignored outside IDLE
    step();
    cfg_load = 1'b0;
    chk("bb1_valid", {31'h0, po_valid}, 32'h1);
    chk("bb1_data", {16'h0, po_data}, 32'h1234);
    chk("bb1_fcnt", {24'h0, frame_cnt}, 32'd9);
    send(40'h5678, 15, 1'b1);
    expect_frame("bb2", 16'h5678, 1'b0, 8'd10);

    // reset after 5 bits of a 16b frame
    send(40'h1F, 5, 1'b1);
    si_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    si_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_valid", {31'h0, po_valid}, 32'h0);
      step();
    end
    chk("rst_mid_fcnt", {24'h0, frame_cnt}, 32'h0);
    chk("rst_mid_busy", {31'h0, rx_busy}, 32'h0);
    load_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send(40'hA55A, 16, 1'b1);
    expect_frame("post_rst", 16'hA55A, 1'b0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
